// File: rtl/vga_plot_arbiter_pkg.sv
// Shared constants and types for the VGA plot-port arbiter.
// The screen geometry matches the 160x120, 9-bit-colour vga_adapter.
package vga_plot_pkg;

   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 9;
   localparam int X_MAX    = 160;
   localparam int Y_MAX    = 120;

   localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 9'h000;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      DRAW,
      FINISH
   } state_e;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester/pixel bundle of the plot arbiter. The animation side (master)
// drives the packed per-requester rectangle requests; the arbiter (slave)
// answers with ack/done/busy and drives the vga_adapter pixel port.
interface vga_plot_arbiter_if
   import vga_plot_pkg::*;
#(
   parameter int N_REQ = 3
);

   logic [N_REQ-1:0]          req;
   logic [N_REQ*X_W-1:0]      req_x;
   logic [N_REQ*Y_W-1:0]      req_y;
   logic [N_REQ*X_W-1:0]      req_w;
   logic [N_REQ*Y_W-1:0]      req_h;
   logic [N_REQ*COLOUR_W-1:0] req_colour;
   logic [N_REQ-1:0]          ack;
   logic [N_REQ-1:0]          done;
   logic                      busy;
   logic [X_W-1:0]            oX;
   logic [Y_W-1:0]            oY;
   logic [COLOUR_W-1:0]       oColour;
   logic                      oPlot;

   modport master (
      output req, req_x, req_y, req_w, req_h, req_colour,
      input  ack, done, busy, oX, oY, oColour, oPlot
   );

   modport slave (
      input  req, req_x, req_y, req_w, req_h, req_colour,
      output ack, done, busy, oX, oY, oColour, oPlot
   );

endinterface

// File: rtl/vga_plot_arbiter_rr.sv
// Combinational round-robin picker: searches req_i starting at ptr_i and
// returns the first asserted requester as a one-hot grant plus its index.
// The pointer register lives in the parent.
module rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o
);

   logic found;
   int   k;

   // Rotating search from the pointer; first asserted request wins.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      k       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         k = (int'(ptr_i) + i) % N_REQ;
         if (!found && req_i[k]) begin
            grant_o[k] = 1'b1;
            idx_o      = IDX_W'(k);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the vga_adapter pixel-write port between N_REQ rectangle-fill
// requesters. One request is granted round-robin, its rectangle is walked
// row-major at one pixel per clock, then done is pulsed to that requester.
// Optional feature: define VGA_PLOT_ARB_CLIP_EN to suppress oPlot for
// pixels falling outside the 160x120 screen instead of wrapping.
module vga_plot_arbiter
   import vga_plot_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input logic clock,
   input logic resetn,
   vga_plot_arbiter_if.slave bus
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e              state_q;
   logic [IDX_W-1:0]    ptr_q, g_q, arb_idx;
   logic [N_REQ-1:0]    arb_gnt, gnt_q, ack_q, done_q;
   logic                busy_q, plot_q;
   logic [X_W-1:0]      x_q, w_q, dx_q, dx_d, ox_q, px_x;
   logic [Y_W-1:0]      y_q, h_q, dy_q, dy_d, oy_q, px_y;
   logic [COLOUR_W-1:0] colour_q, ocol_q;
   logic                last_col, last_row, px_plot;
`ifdef VGA_PLOT_ARB_CLIP_EN
   logic [X_W:0]        sum_x;
   logic [Y_W:0]        sum_y;
`endif

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .grant_o (arb_gnt),
      .idx_o   (arb_idx)
   );

   // Next pixel offset (0,0 from GRANT, row-major step in DRAW) and its screen position.
   always_comb begin
      last_col = (dx_q == w_q - X_W'(1));
      last_row = (dy_q == h_q - Y_W'(1));
      dx_d     = last_col ? '0 : dx_q + X_W'(1);
      dy_d     = last_col ? dy_q + Y_W'(1) : dy_q;
      if (state_q == GRANT) begin
         dx_d = '0;
         dy_d = '0;
      end
`ifdef VGA_PLOT_ARB_CLIP_EN
      sum_x   = {1'b0, x_q} + {1'b0, dx_d};
      sum_y   = {1'b0, y_q} + {1'b0, dy_d};
      px_x    = sum_x[X_W-1:0];
      px_y    = sum_y[Y_W-1:0];
      px_plot = (sum_x < (X_W+1)'(X_MAX)) && (sum_y < (Y_W+1)'(Y_MAX));
`else
      px_x    = x_q + dx_d;
      px_y    = y_q + dy_d;
      px_plot = 1'b1;
`endif
   end

   // Transaction FSM with registered handshake and pixel outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         g_q      <= '0;
         gnt_q    <= '0;
         ack_q    <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         colour_q <= COLOUR_BLACK;
         ox_q     <= '0;
         oy_q     <= '0;
         ocol_q   <= COLOUR_BLACK;
      end else begin
         // NOTE: non-blocking assignments so every register sees the pre-edge values of its peers.
         ack_q  <= '0;
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (|bus.req) begin
                  state_q  <= GRANT;
                  ack_q    <= arb_gnt;
                  gnt_q    <= arb_gnt;
                  g_q      <= arb_idx;
                  busy_q   <= 1'b1;
                  x_q      <= bus.req_x[int'(arb_idx)*X_W +: X_W];
                  y_q      <= bus.req_y[int'(arb_idx)*Y_W +: Y_W];
                  w_q      <= bus.req_w[int'(arb_idx)*X_W +: X_W];
                  h_q      <= bus.req_h[int'(arb_idx)*Y_W +: Y_W];
                  colour_q <= bus.req_colour[int'(arb_idx)*COLOUR_W +: COLOUR_W];
               end
            end
            GRANT: begin
               dx_q <= '0;
               dy_q <= '0;
               if (w_q == '0 || h_q == '0) begin
                  state_q <= FINISH;
                  done_q  <= gnt_q;
               end else begin
                  state_q <= DRAW;
                  plot_q  <= px_plot;
                  ox_q    <= px_x;
                  oy_q    <= px_y;
                  ocol_q  <= colour_q;
               end
            end
            DRAW: begin
               if (last_col && last_row) begin
                  state_q <= FINISH;
                  plot_q  <= 1'b0;
                  done_q  <= gnt_q;
               end else begin
                  dx_q   <= dx_d;
                  dy_q   <= dy_d;
                  plot_q <= px_plot;
                  ox_q   <= px_x;
                  oy_q   <= px_y;
               end
            end
            FINISH: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ptr_q   <= (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + IDX_W'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ack     = ack_q;
   assign bus.done    = done_q;
   assign bus.busy    = busy_q;
   assign bus.oPlot   = plot_q;
   assign bus.oX      = ox_q;
   assign bus.oY      = oy_q;
   assign bus.oColour = ocol_q;

endmodule
